// File: rtl/fetch_queue_if.sv
// fetch_queue_if: memory-request, redirect and decode-side signals of the fetch queue.
interface fetch_queue_if #(
   parameter int ADDR_W  = 16,
   parameter int INSTR_W = 16
);
   logic               halt;
   logic               redirect;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               mem_req;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_done;
   logic [INSTR_W-1:0] mem_data;
   logic               mem_err;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc_next;
   logic               out_err;
   modport master (
      input  halt, redirect, redirect_pc, mem_done, mem_data, mem_err, out_ready,
      output mem_req, mem_addr, out_valid, out_instr, out_pc_next, out_err
   );
   modport slave (
      output halt, redirect, redirect_pc, mem_done, mem_data, mem_err, out_ready,
      input  mem_req, mem_addr, out_valid, out_instr, out_pc_next, out_err
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching fetch unit, one outstanding read, DEPTH-entry FIFO to decode.
// Optional same-cycle memory-to-decode bypass when FETCHQ_BYPASS_EN is defined.
module fetch_queue #(
   parameter int ADDR_W = 16,
   parameter int INSTR_W = 16,
   parameter int DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic clk,
   input logic rst_n,
   fetch_queue_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_W / 8);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   state_t state;
   logic [ADDR_W-1:0] pc, pc_inflight;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] count;
   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [ADDR_W-1:0] pcn_q [DEPTH];
   logic [DEPTH-1:0] err_q;
   logic issue, done, byp, fifo_pop, push, has_head;
   // rst_n gates the request so mem_req reads 0 while reset is held
   assign issue = rst_n & (state == IDLE) & !bus.halt & !bus.redirect & (count != FULL);
   assign done = (state == WAIT) & bus.mem_done;
   assign has_head = count != '0;
   assign bus.mem_req = issue;
   assign bus.mem_addr = pc;
`ifdef FETCHQ_BYPASS_EN
   assign byp = !has_head & done & !bus.redirect;
   assign bus.out_valid = has_head | byp;
   assign bus.out_instr = byp ? bus.mem_data : has_head ? instr_q[rd_ptr] : '0;
   assign bus.out_pc_next = byp ? pc_inflight + STEP : has_head ? pcn_q[rd_ptr] : '0;
   assign bus.out_err = byp ? bus.mem_err : has_head & err_q[rd_ptr];
`else
   assign byp = 1'b0;
   assign bus.out_valid = has_head;
   assign bus.out_instr = has_head ? instr_q[rd_ptr] : '0;
   assign bus.out_pc_next = has_head ? pcn_q[rd_ptr] : '0;
   assign bus.out_err = has_head & err_q[rd_ptr];
`endif
   assign fifo_pop = has_head & bus.out_ready & !bus.redirect;
   // a bypassed response that decode takes immediately never touches storage
   assign push = done & !bus.redirect & !(byp & bus.out_ready);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         pc <= RESET_PC;
         pc_inflight <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
      end else begin
         pc <= bus.redirect ? bus.redirect_pc : issue ? pc + STEP : pc;
         if (issue) pc_inflight <= pc;
         if (bus.redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(push) - (AW + 1)'(fifo_pop);
         end
         unique case (state)
            IDLE: state <= issue ? WAIT : IDLE;
            WAIT: state <= bus.mem_done ? IDLE : bus.redirect ? DROP : WAIT;
            DROP: state <= bus.mem_done ? IDLE : DROP;
            default: state <= IDLE;
         endcase
      end
   always_ff @(posedge clk)
      if (push) begin
         instr_q[wr_ptr] <= bus.mem_data;
         pcn_q[wr_ptr] <= pc_inflight + STEP;
         err_q[wr_ptr] <= bus.mem_err;
      end
endmodule
